// File: rtl/ac97_frame_serializer.sv
// -----------------------------------------------------------------------------
// ac97_frame_serializer
//
// Builds 256-bit AC'97 output frames (16-bit tag + twelve 20-bit slots) and
// shifts them out MSB-first, one bit per I_BITCLK rising edge. Slots 3/4 carry
// the PCM samples. Slots 1/2 carry one buffered codec register write. All
// per-frame inputs are shadowed at the frame boundary, so a frame in flight is
// never disturbed by input changes.
//
// Ports
//   I_BITCLK      in   1   bit clock, all logic on its rising edge
//   I_RESET_N     in   1   asynchronous active-low reset
//   I_ENABLE      in   1   enables frame-valid and PCM-valid tag bits
//   I_LEFT        in  20   slot 3 PCM sample (two's complement)
//   I_RIGHT       in  20   slot 4 PCM sample (two's complement)
//   I_CMD_VALID   in   1   register-write request
//   I_CMD_ADDR    in   7   register address
//   I_CMD_DATA    in  16   register data
//   O_CMD_READY   out  1   command buffer free
//   O_STROBE      out  1   one-cycle sample-request pulse per frame
//   O_SYNC        out  1   frame sync (high during the tag slot)
//   O_SDATA       out  1   serial frame data
// -----------------------------------------------------------------------------
module ac97_frame_serializer (
    input  logic        I_BITCLK,
    input  logic        I_RESET_N,
    input  logic        I_ENABLE,
    input  logic [19:0] I_LEFT,
    input  logic [19:0] I_RIGHT,
    input  logic        I_CMD_VALID,
    input  logic [6:0]  I_CMD_ADDR,
    input  logic [15:0] I_CMD_DATA,
    output logic        O_CMD_READY,
    output logic        O_STROBE,
    output logic        O_SYNC,
    output logic        O_SDATA
);

    typedef enum logic [1:0] {
        CMD_IDLE    = 2'd0,
        CMD_PENDING = 2'd1,
        CMD_SENDING = 2'd2
    } cmd_state_t;

    // Last bit position of each populated slot; slots 5-12 are always zero.
    localparam logic [7:0] TAG_END   = 8'd15;
    localparam logic [7:0] SLOT1_END = 8'd35;
    localparam logic [7:0] SLOT2_END = 8'd55;
    localparam logic [7:0] SLOT3_END = 8'd75;
    localparam logic [7:0] SLOT4_END = 8'd95;
    // Strobe register is loaded one edge early so it is high while P=254.
    localparam logic [7:0] STROBE_PRE = 8'd253;

    // Frame position and registered serial outputs
    logic [7:0]  r_pos;
    logic        r_sync;
    logic        r_sdata;
    logic        r_strobe;

    // Per-frame shadows
    logic        r_sh_enable;
    logic [19:0] r_sh_left;
    logic [19:0] r_sh_right;

    // Command buffer and state
    cmd_state_t  r_cmd_state;
    logic        r_cmd_ready;
    logic [6:0]  r_cmd_addr;
    logic [15:0] r_cmd_data;

    // Combinational frame content
    logic        w_boundary;
    logic        w_cmd_sending;
    logic [15:0] w_tag;
    logic [19:0] w_slot1;
    logic [19:0] w_slot2;
    logic [19:0] w_slot3;
    logic [19:0] w_slot4;
    logic        w_sdata_next;
    logic        w_sync_next;
    logic        w_strobe_next;

    assign w_boundary    = (r_pos == 8'hFF);
    assign w_cmd_sending = (r_cmd_state == CMD_SENDING);

    // Tag: frame valid, cmd addr valid, cmd data valid, left valid, right valid
    assign w_tag   = {r_sh_enable, w_cmd_sending, w_cmd_sending,
                      r_sh_enable, r_sh_enable, 11'b0};
    assign w_slot1 = w_cmd_sending ? {1'b0, r_cmd_addr, 12'b0} : '0;
    assign w_slot2 = w_cmd_sending ? {r_cmd_data, 4'b0}        : '0;
    assign w_slot3 = r_sh_enable   ? r_sh_left                 : '0;
    assign w_slot4 = r_sh_enable   ? r_sh_right                : '0;

    // Select frame bit r_pos. Within a slot ending at position E, frame bit n
    // maps to slot bit (E - n), which gives MSB-first ordering.
    always_comb begin
        w_sdata_next = 1'b0;
        if (r_pos <= TAG_END) begin
            w_sdata_next = w_tag[~r_pos[3:0]];
        end else if (r_pos <= SLOT1_END) begin
            w_sdata_next = w_slot1[5'(SLOT1_END - r_pos)];
        end else if (r_pos <= SLOT2_END) begin
            w_sdata_next = w_slot2[5'(SLOT2_END - r_pos)];
        end else if (r_pos <= SLOT3_END) begin
            w_sdata_next = w_slot3[5'(SLOT3_END - r_pos)];
        end else if (r_pos <= SLOT4_END) begin
            w_sdata_next = w_slot4[5'(SLOT4_END - r_pos)];
        end
    end

    assign w_sync_next   = (r_pos <= TAG_END);
    assign w_strobe_next = (r_pos == STROBE_PRE);

    // Position counter, serial outputs and frame shadows
    always_ff @(posedge I_BITCLK or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            r_pos       <= '0;
            r_sync      <= 1'b0;
            r_sdata     <= 1'b0;
            r_strobe    <= 1'b0;
            r_sh_enable <= 1'b0;
            r_sh_left   <= '0;
            r_sh_right  <= '0;
        end else begin
            r_pos    <= r_pos + 8'd1;
            r_sync   <= w_sync_next;
            r_sdata  <= w_sdata_next;
            r_strobe <= w_strobe_next;
            if (w_boundary) begin
                r_sh_enable <= I_ENABLE;
                r_sh_left   <= I_LEFT;
                r_sh_right  <= I_RIGHT;
            end
        end
    end

    // Command FSM. State changes other than acceptance happen only on the
    // frame boundary, so a command occupies exactly one whole frame. A
    // command accepted on the boundary edge itself lands in PENDING and waits
    // a full frame.
    always_ff @(posedge I_BITCLK or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            r_cmd_state <= CMD_IDLE;
            r_cmd_ready <= 1'b1;
            r_cmd_addr  <= '0;
            r_cmd_data  <= '0;
        end else begin
            case (r_cmd_state)
                CMD_IDLE: begin
                    if (I_CMD_VALID) begin
                        r_cmd_addr  <= I_CMD_ADDR;
                        r_cmd_data  <= I_CMD_DATA;
                        r_cmd_state <= CMD_PENDING;
                        r_cmd_ready <= 1'b0;
                    end
                end
                CMD_PENDING: begin
                    if (w_boundary) begin
                        r_cmd_state <= CMD_SENDING;
                    end
                end
                CMD_SENDING: begin
                    if (w_boundary) begin
                        r_cmd_state <= CMD_IDLE;
                        r_cmd_ready <= 1'b1;
                    end
                end
                default: begin
                    r_cmd_state <= CMD_IDLE;
                    r_cmd_ready <= 1'b1;
                end
            endcase
        end
    end

    assign O_SYNC      = r_sync;
    assign O_SDATA     = r_sdata;
    assign O_STROBE    = r_strobe;
    assign O_CMD_READY = r_cmd_ready;

endmodule

// File: tb/tb_ac97_frame_serializer.sv
// -----------------------------------------------------------------------------
// Directed bench for ac97_frame_serializer. Frames are captured bit by bit
// after each edge and decoded into tag / slot fields, which are compared with
// hand-computed constants.
// -----------------------------------------------------------------------------
module tb_ac97_frame_serializer;

    logic        I_BITCLK;
    logic        I_RESET_N;
    logic        I_ENABLE;
    logic [19:0] I_LEFT;
    logic [19:0] I_RIGHT;
    logic        I_CMD_VALID;
    logic [6:0]  I_CMD_ADDR;
    logic [15:0] I_CMD_DATA;
    logic        O_CMD_READY;
    logic        O_STROBE;
    logic        O_SYNC;
    logic        O_SDATA;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [7:0]  p_tb;          // bench copy of the DUT position counter
    logic [19:0] sv_left, sv_right;
    logic        sv_en;
    logic [255:0] fb;

    ac97_frame_serializer dut (
        .I_BITCLK    (I_BITCLK),
        .I_RESET_N   (I_RESET_N),
        .I_ENABLE    (I_ENABLE),
        .I_LEFT      (I_LEFT),
        .I_RIGHT     (I_RIGHT),
        .I_CMD_VALID (I_CMD_VALID),
        .I_CMD_ADDR  (I_CMD_ADDR),
        .I_CMD_DATA  (I_CMD_DATA),
        .O_CMD_READY (O_CMD_READY),
        .O_STROBE    (O_STROBE),
        .O_SYNC      (O_SYNC),
        .O_SDATA     (O_SDATA)
    );

    initial I_BITCLK = 1'b0;
    always #5 I_BITCLK = ~I_BITCLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no finish, expected finish before 1 ms");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge I_BITCLK);
        #1;
        p_tb = p_tb + 8'd1;
    endtask

    function automatic logic [31:0] field(input logic [255:0] f, input int unsigned start,
                                          input int unsigned len);
        logic [31:0] v;
        v = '0;
        for (int unsigned j = 0; j < len; j++) v = {v[30:0], f[start + j]};
        return v;
    endfunction

    // act: 0 none, 1 input glitch mid-frame, 2 command at P=100 plus ignored
    // second request at P=150, 4 command at P=255, 5 command at P=10
    task automatic run_frame(input string nm, input int act, output logic [255:0] f);
        int unsigned bad_sync, bad_strobe;
        bad_sync = 0;
        bad_strobe = 0;
        f = '0;
        for (int i = 0; i < 256; i++) begin
            if (act == 1 && p_tb == 8'd100) begin
                I_LEFT = 20'h55555; I_RIGHT = 20'h0AAAA; I_ENABLE = ~sv_en;
            end
            if (act == 1 && p_tb == 8'd200) begin
                I_LEFT = sv_left; I_RIGHT = sv_right; I_ENABLE = sv_en;
            end
            if (act == 2 && p_tb == 8'd100) begin
                I_CMD_VALID = 1'b1; I_CMD_ADDR = 7'h02; I_CMD_DATA = 16'h8000;
            end
            if (act == 2 && p_tb == 8'd150) begin
                I_CMD_VALID = 1'b1; I_CMD_ADDR = 7'h55; I_CMD_DATA = 16'h1234;
            end
            if (act == 4 && p_tb == 8'd255) begin
                I_CMD_VALID = 1'b1; I_CMD_ADDR = 7'h11; I_CMD_DATA = 16'hBEEF;
            end
            if (act == 5 && p_tb == 8'd10) begin
                I_CMD_VALID = 1'b1; I_CMD_ADDR = 7'h7F; I_CMD_DATA = 16'hFFFF;
            end
            tick();
            I_CMD_VALID = 1'b0;
            f[i] = O_SDATA;
            if (O_SYNC !== (i < 16)) bad_sync++;
            if (O_STROBE !== (p_tb == 8'd254)) bad_strobe++;
            if (act == 2 && p_tb == 8'd99)  check({nm, "_ready_before"}, 32'(O_CMD_READY), 32'd1);
            if (act == 2 && p_tb == 8'd101) check({nm, "_ready_drop"},   32'(O_CMD_READY), 32'd0);
        end
        check({nm, "_sync_badbits"},   bad_sync,   32'd0);
        check({nm, "_strobe_badbits"}, bad_strobe, 32'd0);
    endtask

    task automatic check_frame(input string nm, input logic [255:0] f, input logic [31:0] tag,
                               input logic [31:0] s1, input logic [31:0] s2,
                               input logic [31:0] s3, input logic [31:0] s4);
        check({nm, "_tag"},   field(f, 0, 16),  tag);
        check({nm, "_slot1"}, field(f, 16, 20), s1);
        check({nm, "_slot2"}, field(f, 36, 20), s2);
        check({nm, "_slot3"}, field(f, 56, 20), s3);
        check({nm, "_slot4"}, field(f, 76, 20), s4);
        check({nm, "_slots5_12"}, 32'(|f[255:96]), 32'd0);
    endtask

    task automatic check_reset_outputs(input string nm);
        check({nm, "_sync"},   32'(O_SYNC),      32'd0);
        check({nm, "_sdata"},  32'(O_SDATA),     32'd0);
        check({nm, "_strobe"}, 32'(O_STROBE),    32'd0);
        check({nm, "_ready"},  32'(O_CMD_READY), 32'd1);
    endtask

    initial begin
        I_RESET_N = 1'b0; I_ENABLE = 1'b0; I_LEFT = '0; I_RIGHT = '0;
        I_CMD_VALID = 1'b0; I_CMD_ADDR = '0; I_CMD_DATA = '0;
        p_tb = '0;
        repeat (3) @(posedge I_BITCLK);
        #1;
        check_reset_outputs("rst0");

        @(negedge I_BITCLK);
        I_RESET_N = 1'b1;
        p_tb = '0;

        // Three frames with enable low: only sync and strobe activity
        run_frame("f0", 0, fb); check_frame("f0", fb, 32'h0000, 0, 0, 0, 0);
        run_frame("f1", 0, fb); check_frame("f1", fb, 32'h0000, 0, 0, 0, 0);
        sv_en = 1'b1; sv_left = 20'h12345; sv_right = 20'hFEDCB;
        I_ENABLE = sv_en; I_LEFT = sv_left; I_RIGHT = sv_right;
        run_frame("f2", 0, fb); check_frame("f2", fb, 32'h0000, 0, 0, 0, 0);

        // Samples latched; inputs glitch mid-frame without effect
        run_frame("f3", 1, fb);
        check_frame("f3", fb, 32'h9800, 0, 0, 32'h12345, 32'hFEDCB);

        // Command accepted at P=100, second request ignored; pending this frame
        run_frame("f4", 2, fb);
        check_frame("f4", fb, 32'h9800, 0, 0, 32'h12345, 32'hFEDCB);
        check("f4_ready_end", 32'(O_CMD_READY), 32'd0);

        run_frame("f5", 0, fb);
        check_frame("f5", fb, 32'hF800, 32'h02000, 32'h80000, 32'h12345, 32'hFEDCB);
        check("f5_ready_end", 32'(O_CMD_READY), 32'd1);

        // Command accepted on the boundary cycle P=255
        run_frame("f6", 4, fb);
        check_frame("f6", fb, 32'h9800, 0, 0, 32'h12345, 32'hFEDCB);
        check("f6_ready_end", 32'(O_CMD_READY), 32'd0);

        // Enable drop does not cancel the pending command
        sv_en = 1'b0; I_ENABLE = 1'b0;
        run_frame("f7", 0, fb);
        check_frame("f7", fb, 32'h9800, 0, 0, 32'h12345, 32'hFEDCB);
        check("f7_ready_end", 32'(O_CMD_READY), 32'd0);

        run_frame("f8", 0, fb);
        check_frame("f8", fb, 32'h6000, 32'h11000, 32'hBEEF0, 0, 0);
        check("f8_ready_end", 32'(O_CMD_READY), 32'd1);

        // Command pending in f9, sending in f10, reset pulsed at P=120
        sv_en = 1'b1; I_ENABLE = 1'b1;
        run_frame("f9", 5, fb);
        check_frame("f9", fb, 32'h0000, 0, 0, 0, 0);
        for (int i = 0; i < 120; i++) tick();
        check("f10_ready_sending", 32'(O_CMD_READY), 32'd0);
        I_RESET_N = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        repeat (2) @(posedge I_BITCLK);
        #1;
        check_reset_outputs("rst_hold");
        @(negedge I_BITCLK);
        I_RESET_N = 1'b1;
        p_tb = '0;

        // First frame after reset uses zero shadows; command was discarded
        run_frame("f11", 0, fb);
        check_frame("f11", fb, 32'h0000, 0, 0, 0, 0);
        run_frame("f12", 0, fb);
        check_frame("f12", fb, 32'h9800, 0, 0, 32'h12345, 32'hFEDCB);
        check("f12_ready_end", 32'(O_CMD_READY), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
